// File: rtl/wb_src_arb_pkg.sv
// Shared constants for the six-way write-back source select path.
// Index constants match the select encoding used by the decoder and the write-back mux.
package wb_src_arb_pkg;

  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_IDLE = 3'b111;
  localparam sel_t SRC_ALU  = 3'd0;
  localparam sel_t SRC_MEM  = 3'd1;
  localparam sel_t SRC_HI   = 3'd2;
  localparam sel_t SRC_LO   = 3'd3;
  localparam sel_t SRC_CP0  = 3'd4;
  localparam sel_t SRC_LINK = 3'd5;

  // Step to the next source index, wrapping LINK back to ALU.
  function automatic sel_t sel_inc(input sel_t sel);
    sel_t nxt;
    if (sel >= SRC_LINK) begin
      nxt = SRC_ALU;
    end else begin
      nxt = sel + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational rotating-priority encoder over six requesters.
// Searches upward from ptr (mod 6); an out-of-range ptr behaves as 0.
module rr_pick6
  import wb_src_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  sel_t base_s;
  sel_t cand_s;
  logic found_s;
  logic hit_s;

  assign base_s = (ptr > SRC_LINK) ? SRC_ALU : ptr;

  // Walk the six candidates in priority order and keep the first hit.
  always_comb begin
    gnt     = '0;
    idx     = SEL_IDLE;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = base_s;
    for (int k = 0; k < NUM_SRC; k++) begin
      hit_s       = ~found_s & req[cand_s];
      gnt[cand_s] = gnt[cand_s] | hit_s;
      idx         = hit_s ? cand_s : idx;
      found_s     = found_s | hit_s;
      cand_s      = sel_inc(cand_s);
    end
  end

  assign any = found_s;

endmodule

// File: rtl/wb_src_arbiter_chk.sv
// Protocol checker for wb_src_arbiter outputs; attach alongside an instance.
// Holds grant exclusivity, select encoding and stall-hold properties.
module wb_src_arbiter_chk
  import wb_src_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_SRC-1:0] Gnt,
  input logic [SEL_W-1:0]   Order,
  input logic [DATA_W-1:0]  DataOut,
  input logic               Valid,
  input logic               Ready
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(Gnt));

  a_no_sel6: assert property (@(posedge clk) disable iff (!rst_n)
    Order != 3'b110);

  a_idle_iff_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (Order == SEL_IDLE) == !Valid);

  a_stall_no_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (Valid && !Ready) |-> (Gnt == {NUM_SRC{1'b0}}));

  a_stall_hold: assert property (@(posedge clk)
    (rst_n && Valid && !Ready) |=> ($stable(DataOut) && $stable(Order) && $stable(Valid)));

endmodule

// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter and output register for the six-way write-back select path.
// Optional feature macro: WB_SRC_ARB_LOCK_EN adds the Lock input (winner keeps priority).
module wb_src_arbiter
  import wb_src_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SRC-1:0] Req,
  input  logic [DATA_W-1:0] DataIn0,
  input  logic [DATA_W-1:0] DataIn1,
  input  logic [DATA_W-1:0] DataIn2,
  input  logic [DATA_W-1:0] DataIn3,
  input  logic [DATA_W-1:0] DataIn4,
  input  logic [DATA_W-1:0] DataIn5,
`ifdef WB_SRC_ARB_LOCK_EN
  input  logic [NUM_SRC-1:0] Lock,
`endif
  input  logic              Ready,
  output logic [NUM_SRC-1:0] Gnt,
  output logic [SEL_W-1:0]  Order,
  output logic [DATA_W-1:0] DataOut,
  output logic              Valid
);

  logic              valid_r;
  sel_t              order_r;
  sel_t              ptr_r;
  logic [DATA_W-1:0] data_r;

  logic [NUM_SRC-1:0] pick_gnt_s;
  sel_t               win_idx_s;
  sel_t               ptr_nxt_s;
  logic               pick_any_s;
  logic               free_s;
  logic               accept_s;
  logic               lock_hit_s;
  logic [DATA_W-1:0]  win_data_s;

  rr_pick6 u_pick (
    .req (Req),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (win_idx_s),
    .any (pick_any_s)
  );

  assign free_s   = ~valid_r | Ready;
  // Reset gates the grant so no producer believes it was accepted during reset.
  assign accept_s = rst_n & free_s & pick_any_s;
  assign Gnt      = accept_s ? pick_gnt_s : {NUM_SRC{1'b0}};

  // Steer the winning source's data toward the output register.
  always_comb begin
    win_data_s = '0;
    case (win_idx_s)
      SRC_ALU:  win_data_s = DataIn0;
      SRC_MEM:  win_data_s = DataIn1;
      SRC_HI:   win_data_s = DataIn2;
      SRC_LO:   win_data_s = DataIn3;
      SRC_CP0:  win_data_s = DataIn4;
      SRC_LINK: win_data_s = DataIn5;
      default:  win_data_s = '0;
    endcase
  end

`ifdef WB_SRC_ARB_LOCK_EN
  assign lock_hit_s = |(Lock & pick_gnt_s);
`else
  assign lock_hit_s = 1'b0;
`endif

  assign ptr_nxt_s = lock_hit_s ? win_idx_s : sel_inc(win_idx_s);

  // Output register, occupancy flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      order_r <= SEL_IDLE;
      data_r  <= '0;
      ptr_r   <= SRC_ALU;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      order_r <= win_idx_s;
      data_r  <= win_data_s;
      ptr_r   <= ptr_nxt_s;
    end else if (free_s) begin
      valid_r <= 1'b0;
      order_r <= SEL_IDLE;
    end else begin
      valid_r <= valid_r;
      order_r <= order_r;
      data_r  <= data_r;
      ptr_r   <= ptr_r;
    end
  end

  assign Valid   = valid_r;
  assign Order   = order_r;
  assign DataOut = data_r;

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Scenario-driven bench for wb_src_arbiter with a queue of expected write-back results.
// Build with WB_SRC_ARB_LOCK_EN defined to also exercise the Lock path.
module tb_wb_src_arbiter;

  typedef struct packed {
    logic [2:0]  ord;
    logic [31:0] data;
  } exp_t;

  localparam exp_t NONE = '{ord: 3'b110, data: 32'h0};

  logic        clk;
  logic        rst_n;
  logic [5:0]  Req;
  logic [31:0] din [6];
  logic [5:0]  lock;
  logic        Ready;
  logic [5:0]  Gnt;
  logic [2:0]  Order;
  logic [31:0] DataOut;
  logic        Valid;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  wb_src_arbiter #(.DATA_W(32), .NUM_SRC(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Req     (Req),
    .DataIn0 (din[0]),
    .DataIn1 (din[1]),
    .DataIn2 (din[2]),
    .DataIn3 (din[3]),
    .DataIn4 (din[4]),
    .DataIn5 (din[5]),
`ifdef WB_SRC_ARB_LOCK_EN
    .Lock    (lock),
`endif
    .Ready   (Ready),
    .Gnt     (Gnt),
    .Order   (Order),
    .DataOut (DataOut),
    .Valid   (Valid)
  );

  wb_src_arbiter_chk #(.DATA_W(32)) chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .Gnt     (Gnt),
    .Order   (Order),
    .DataOut (DataOut),
    .Valid   (Valid),
    .Ready   (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    Req   = 6'h3F;
    Ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (Gnt !== 6'h00) begin errors++; $display("FAIL reset_gnt got %b exp %b", Gnt, 6'h00); end
      if (c > 0) begin
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Valid); end
        checks++; if (Order !== 3'b111) begin errors++; $display("FAIL reset_order got %b exp 111", Order); end
        checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", DataOut); end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    Req   = 6'h00;
  endtask

  task automatic test_single();
    exp_t e;
    din[2] = 32'hDEADBEEF;
    Req    = 6'b000100;
    Ready  = 1'b1;
    @(negedge clk);
    checks++; if (Gnt !== 6'b000100) begin errors++; $display("FAIL single_gnt got %b exp %b", Gnt, 6'b000100); end
    exp_q.push_back('{ord: 3'd2, data: 32'hDEADBEEF});
    @(posedge clk); #1;
    Req = 6'h00;
    @(negedge clk);
    checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", Valid); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL single_out got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_wrap();
    exp_t e;
    logic [2:0] w;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    Req   = 6'h3F;
    Ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      w = 3'(k % 6);
      @(negedge clk);
      checks++; if (Gnt !== (6'b000001 << w)) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, Gnt, 6'b000001 << w); end
      if (k > 0) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
        checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL rr_out[%0d] got %h/%h exp %h/%h", k, Order, DataOut, e.ord, e.data); end
      end
      exp_q.push_back('{ord: w, data: din[w]});
      @(posedge clk); #1;
    end
    Req = 6'h00;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL rr_out_last got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    Req   = 6'b100001;
    Ready = 1'b1;
    @(negedge clk);
    checks++; if (Gnt !== 6'b100000) begin errors++; $display("FAIL bp_first_gnt got %b exp %b", Gnt, 6'b100000); end
    exp_q.push_back('{ord: 3'd5, data: din[5]});
    @(posedge clk); #1;
    Ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (Gnt !== 6'h00) begin errors++; $display("FAIL bp_stall_gnt[%0d] got %b exp 0", c, Gnt); end
      checks++; if ({Valid, Order, DataOut} !== {1'b1, 3'd5, din[5]}) begin errors++; $display("FAIL bp_stall_out[%0d] got %b/%h/%h exp 1/5/%h", c, Valid, Order, DataOut, din[5]); end
      @(posedge clk); #1;
    end
    Ready = 1'b1;
    @(negedge clk);
    checks++; if (Gnt !== 6'b000001) begin errors++; $display("FAIL bp_resume_gnt got %b exp %b", Gnt, 6'b000001); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL bp_out5 got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    exp_q.push_back('{ord: 3'd0, data: din[0]});
    @(posedge clk); #1;
    Req = 6'b100000;
    @(negedge clk);
    checks++; if (Gnt !== 6'b100000) begin errors++; $display("FAIL bp_next_gnt got %b exp %b", Gnt, 6'b100000); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL bp_out0 got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    exp_q.push_back('{ord: 3'd5, data: din[5]});
    @(posedge clk); #1;
    Req = 6'h00;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL bp_out5b got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_withdrawn();
    exp_t e;
    Req   = 6'b000001;
    Ready = 1'b1;
    @(negedge clk);
    checks++; if (Gnt !== 6'b000001) begin errors++; $display("FAIL wd_gnt0 got %b exp %b", Gnt, 6'b000001); end
    exp_q.push_back('{ord: 3'd0, data: din[0]});
    @(posedge clk); #1;
    Req   = 6'b001000;
    Ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (Gnt !== 6'h00) begin errors++; $display("FAIL wd_gnt[%0d] got %b exp 0", c, Gnt); end
      checks++; if (Order !== 3'd0) begin errors++; $display("FAIL wd_order[%0d] got %0d exp 0", c, Order); end
      @(posedge clk); #1;
      Req = 6'h00;
    end
    Ready = 1'b1;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL wd_out got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({Valid, Order} !== {1'b0, 3'b111}) begin errors++; $display("FAIL wd_idle got %b/%b exp 0/111", Valid, Order); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    Req   = 6'b000010;
    Ready = 1'b1;
    @(negedge clk);
    checks++; if (Gnt !== 6'b000010) begin errors++; $display("FAIL rm_gnt1 got %b exp %b", Gnt, 6'b000010); end
    exp_q.push_back('{ord: 3'd1, data: din[1]});
    @(posedge clk); #1;
    Req   = 6'h3F;
    Ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (Gnt !== 6'h00) begin errors++; $display("FAIL rm_gnt_in_reset got %b exp 0", Gnt); end
    @(posedge clk);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    Ready = 1'b1;
    @(negedge clk);
    checks++; if ({Valid, Order, DataOut} !== {1'b0, 3'b111, 32'h0}) begin errors++; $display("FAIL rm_cleared got %b/%b/%h exp 0/111/0", Valid, Order, DataOut); end
    checks++; if (Gnt !== 6'b000001) begin errors++; $display("FAIL rm_ptr0_gnt got %b exp %b", Gnt, 6'b000001); end
    exp_q.push_back('{ord: 3'd0, data: din[0]});
    @(posedge clk); #1;
    Req = 6'h00;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL rm_out got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] mptr;
    logic       mvalid;
    logic [5:0] r;
    logic [5:0] eg;
    logic       rdy;
    logic       free;
    logic       acc;
    logic [2:0] w;
    int         c;
    mptr   = 3'd1;
    mvalid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      r     = 6'($urandom_range(0, 63));
      rdy   = ($urandom_range(0, 3) != 0);
      Req   = r;
      Ready = rdy;
      @(negedge clk);
      free = !mvalid || rdy;
      acc  = 1'b0;
      w    = 3'd0;
      eg   = 6'h00;
      if (free) begin
        for (int k = 0; k < 6; k++) begin
          c = (int'(mptr) + k) % 6;
          if (!acc && r[c]) begin acc = 1'b1; w = 3'(c); end
        end
      end
      if (acc) eg = 6'b000001 << w;
      checks++; if (Gnt !== eg) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp %b", n, Gnt, eg); end
      checks++; if (Valid !== mvalid) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", n, Valid, mvalid); end
      if (mvalid && rdy) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
        checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL b2b_out[%0d] got %h/%h exp %h/%h", n, Order, DataOut, e.ord, e.data); end
      end
      if (acc) exp_q.push_back('{ord: w, data: din[w]});
      @(posedge clk); #1;
      if (acc) begin
        mvalid = 1'b1;
        mptr   = (w == 3'd5) ? 3'd0 : w + 3'd1;
      end else if (free) begin
        mvalid = 1'b0;
      end
    end
    Req   = 6'h00;
    Ready = 1'b1;
    @(negedge clk);
    if (mvalid) begin
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
      checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL b2b_drain got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    end
    @(posedge clk); #1;
  endtask

`ifdef WB_SRC_ARB_LOCK_EN
  task automatic test_lock();
    exp_t       e;
    logic [5:0] eg;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    Req   = 6'b010010;
    Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lock = (k < 2) ? 6'b000010 : 6'b000000;
      eg   = (k < 3) ? 6'b000010 : 6'b010000;
      @(negedge clk);
      checks++; if (Gnt !== eg) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp %b", k, Gnt, eg); end
      if (k > 0) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
        checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL lock_out[%0d] got %h/%h exp %h/%h", k, Order, DataOut, e.ord, e.data); end
      end
      exp_q.push_back((k < 3) ? exp_t'('{ord: 3'd1, data: din[1]}) : exp_t'('{ord: 3'd4, data: din[4]}));
      @(posedge clk); #1;
    end
    Req  = 6'h00;
    lock = 6'h00;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = NONE;
    checks++; if ({Order, DataOut} !== e) begin errors++; $display("FAIL lock_out_last got %h/%h exp %h/%h", Order, DataOut, e.ord, e.data); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    Req    = 6'h00;
    Ready  = 1'b0;
    lock   = 6'h00;
    for (int i = 0; i < 6; i++) din[i] = 32'h5A00_0000 + 32'(i) * 32'h0011_1111;
    test_reset();
    test_single();
    test_rr_wrap();
    test_backpressure();
    test_withdrawn();
    test_reset_mid();
    test_back_to_back();
`ifdef WB_SRC_ARB_LOCK_EN
    test_lock();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_empty got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
